simd_unpack_seq: RTL and testbench



---
 rtl/simd_unpack_seq.sv | 190 +++++++++++++++++++
 tb/tb_simd_unpack_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_unpack_seq.sv
// Sequencing controller for the SIMD unpack datapath: latches one command, then
// streams one or two interleaved 256-bit result beats through an internal packer.

module simd_packer #(
    parameter int SIMD_WIDTH = 256
) (
    input  logic [SIMD_WIDTH-1:0] a,
    input  logic [SIMD_WIDTH-1:0] b,
    input  logic [2:0]            mode,
    input  logic                  hi_flag,
    output logic [SIMD_WIDTH-1:0] data
);
    localparam int HALF = SIMD_WIDTH / 2;

    logic [HALF-1:0] a_half_s;
    logic [HALF-1:0] b_half_s;

    // LO and HI differ only in which source half feeds the interleave.
    always_comb begin
        if (hi_flag) begin
            a_half_s = a[SIMD_WIDTH-1:HALF];
            b_half_s = b[SIMD_WIDTH-1:HALF];
        end else begin
            a_half_s = a[HALF-1:0];
            b_half_s = b[HALF-1:0];
        end
    end

    // Interleave element pairs of the selected half, A element above B element.
    always_comb begin
        data = {SIMD_WIDTH{1'b0}};
        case (mode)
            3'd0: begin
                for (int i = 0; i < HALF / 8; i++) begin
                    data[16*i +: 16] = {a_half_s[8*i +: 8], b_half_s[8*i +: 8]};
                end
            end
            3'd1: begin
                for (int i = 0; i < HALF / 16; i++) begin
                    data[32*i +: 32] = {a_half_s[16*i +: 16], b_half_s[16*i +: 16]};
                end
            end
            3'd2: begin
                for (int i = 0; i < HALF / 32; i++) begin
                    data[64*i +: 64] = {a_half_s[32*i +: 32], b_half_s[32*i +: 32]};
                end
            end
            3'd3: begin
                for (int i = 0; i < HALF / 64; i++) begin
                    data[128*i +: 128] = {a_half_s[64*i +: 64], b_half_s[64*i +: 64]};
                end
            end
            3'd4: begin
                data = {a_half_s, b_half_s};
            end
            default: begin
                data = a;
            end
        endcase
    end
endmodule

module simd_unpack_seq #(
    parameter int SIMD_WIDTH = 256,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIMD_WIDTH-1:0] in_a,
    input  logic [SIMD_WIDTH-1:0] in_b,
    input  logic [2:0]            in_mode,
    input  logic [1:0]            in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIMD_WIDTH-1:0] out_data,
    output logic                  out_hi,
    output logic                  out_last,
    output logic                  busy,
    output logic [CNT_W-1:0]      done_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                  state_r;
    logic [SIMD_WIDTH-1:0]   a_r;
    logic [SIMD_WIDTH-1:0]   b_r;
    logic [2:0]              mode_r;
    logic                    accept_s;
    logic                    out_fire_s;

    assign accept_s   = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

    // Operand capture; deliberately not cleared so the registers only toggle on accept.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            a_r    <= in_a;
            b_r    <= in_b;
            mode_r <= in_mode;
        end else begin
            a_r    <= a_r;
            b_r    <= b_r;
            mode_r <= mode_r;
        end
    end

    // Beat sequencer; every handshake-visible output is a register, so out_ready never reaches in_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_hi    <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done_cnt  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r   <= ST_BEAT0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        // op bit 0 selects HI first, op bit 1 requests the second half too
                        out_hi    <= in_op[0];
                        out_last  <= ~in_op[1];
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_BEAT0: begin
                    if (out_fire_s && out_last) begin
                        state_r   <= ST_IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        out_hi    <= 1'b0;
                        out_last  <= 1'b0;
                        done_cnt  <= done_cnt + CNT_ONE;
                    end else if (out_fire_s) begin
                        state_r   <= ST_BEAT1;
                        out_hi    <= ~out_hi;
                        out_last  <= 1'b1;
                    end else begin
                        state_r   <= ST_BEAT0;
                    end
                end
                ST_BEAT1: begin
                    if (out_fire_s) begin
                        state_r   <= ST_IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        out_hi    <= 1'b0;
                        out_last  <= 1'b0;
                        done_cnt  <= done_cnt + CNT_ONE;
                    end else begin
                        state_r   <= ST_BEAT1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    out_hi    <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    simd_packer #(
        .SIMD_WIDTH (SIMD_WIDTH)
    ) u_packer (
        .a       (a_r),
        .b       (b_r),
        .mode    (mode_r),
        .hi_flag (out_hi),
        .data    (out_data)
    );
endmodule

// File: tb/tb_simd_unpack_seq.sv
// Directed bench for simd_unpack_seq: a beat-queue reference model checked every
// cycle, plus hand-computed literal expectations at key points.

module tb_simd_unpack_seq;
    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_a;
    logic [255:0] in_b;
    logic [2:0]   in_mode;
    logic [1:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic         out_hi;
    logic         out_last;
    logic         busy;
    logic [3:0]   done_cnt;

    simd_unpack_seq #(.SIMD_WIDTH(256), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_hi(out_hi), .out_last(out_last), .busy(busy), .done_cnt(done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [255:0] d;
        logic         hi;
        logic         last;
    } beat_t;

    beat_t      q[$];
    logic [3:0] exp_done;
    int         n_pass  = 0;
    int         n_total = 0;
    int         cyc     = 0;
    int         acc_cyc = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference unpack: result element k of width e takes pair k/2 from the chosen half; odd k from A.
    function automatic logic [255:0] model_pack(input logic [255:0] a, input logic [255:0] b,
                                                input int mode, input bit hi);
        logic [255:0] r;
        int e, k, src, sb;
        if (mode >= 5) return a;
        e = 8 << mode;
        for (int j = 0; j < 256; j++) begin
            k   = j / e;
            src = (k / 2) + (hi ? (128 / e) : 0);
            sb  = src * e + (j % e);
            r[j] = (k % 2 == 1) ? a[sb] : b[sb];
        end
        return r;
    endfunction

    function automatic beat_t mk(input logic [255:0] d, input logic hi, input logic last);
        beat_t t;
        t.d = d; t.hi = hi; t.last = last;
        return t;
    endfunction

    always @(negedge clk) cyc++;

    // Model: a command expands into its ordered beats; a beat leaves when the consumer is ready.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_done <= 4'd0;
        end else if (q.size() > 0) begin
            if (out_ready) begin
                if (q[0].last) exp_done <= exp_done + 4'd1;
                void'(q.pop_front());
            end
        end else if (in_valid) begin
            case (in_op)
                2'd0: q.push_back(mk(model_pack(in_a, in_b, int'(in_mode), 1'b0), 1'b0, 1'b1));
                2'd1: q.push_back(mk(model_pack(in_a, in_b, int'(in_mode), 1'b1), 1'b1, 1'b1));
                2'd2: begin
                    q.push_back(mk(model_pack(in_a, in_b, int'(in_mode), 1'b0), 1'b0, 1'b0));
                    q.push_back(mk(model_pack(in_a, in_b, int'(in_mode), 1'b1), 1'b1, 1'b1));
                end
                default: begin
                    q.push_back(mk(model_pack(in_a, in_b, int'(in_mode), 1'b1), 1'b1, 1'b0));
                    q.push_back(mk(model_pack(in_a, in_b, int'(in_mode), 1'b0), 1'b0, 1'b1));
                end
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() == 0);
            chk("busy", busy, q.size() > 0);
            chk("done_cnt", done_cnt, exp_done);
            if (q.size() > 0) begin
                chk("out_data", out_data, q[0].d);
                chk("out_hi", out_hi, q[0].hi);
                chk("out_last", out_last, q[0].last);
            end
        end
    end

    task automatic send_cmd(input logic [255:0] a, input logic [255:0] b,
                            input logic [2:0] mode, input logic [1:0] op);
        bit ok;
        ok = 1'b0;
        in_a = a; in_b = b; in_mode = mode; in_op = op; in_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
        chk("accept_timeout", ok, 1'b1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", ok, 1'b1);
    endtask

    logic [255:0] ta, tb, hi_lit, lo_lit, pa, pb;
    int           prev_acc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_mode = 3'd0; in_op = 2'd0; out_ready = 1'b1;

        // Literal pins of the reference unpack itself.
        pa = {64'h3, 64'h2, 64'h1, 64'h0};
        pb = {64'h13, 64'h12, 64'h11, 64'h10};
        chk("model_m3_lo", model_pack(pa, pb, 3, 1'b0), {64'h1, 64'h11, 64'h0, 64'h10});
        chk("model_m3_hi", model_pack(pa, pb, 3, 1'b1), {64'h3, 64'h13, 64'h2, 64'h12});
        chk("model_m0_lo", model_pack({32{8'hAA}}, {32{8'h55}}, 0, 1'b0), {16{16'hAA55}});

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done_cnt", done_cnt, 4'd0);

        // Mode 4 LO then HI with a ready consumer.
        ta     = {{32{4'h1}}, {32{4'h2}}};
        tb     = {{32{4'h3}}, {32{4'h4}}};
        lo_lit = {{32{4'h2}}, {32{4'h4}}};
        hi_lit = {{32{4'h1}}, {32{4'h3}}};
        send_cmd(ta, tb, 3'd4, 2'd2);
        chk("m4_b0_valid", out_valid, 1'b1);
        chk("m4_b0_data", out_data, lo_lit);
        chk("m4_b0_hi", out_hi, 1'b0);
        chk("m4_b0_last", out_last, 1'b0);
        @(posedge clk); #1;
        chk("m4_b1_data", out_data, hi_lit);
        chk("m4_b1_hi", out_hi, 1'b1);
        chk("m4_b1_last", out_last, 1'b1);
        @(posedge clk); #1;
        chk("m4_done", done_cnt, 4'd1);
        chk("m4_idle_ready", in_ready, 1'b1);

        // Backpressure on HI-then-LO.
        out_ready = 1'b0;
        send_cmd(ta, tb, 3'd4, 2'd3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", out_data, hi_lit);
            chk("bp_hold_hi", out_hi, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_lo_data", out_data, lo_lit);
        chk("bp_lo_last", out_last, 1'b1);
        @(posedge clk); #1;
        chk("bp_done", done_cnt, 4'd2);

        // Mode 6 passes A through on both beats.
        send_cmd(hi_lit, tb, 3'd6, 2'd2);
        chk("m6_b0_data", out_data, hi_lit);
        chk("m6_b0_last", out_last, 1'b0);
        @(posedge clk); #1;
        chk("m6_b1_data", out_data, hi_lit);
        chk("m6_b1_last", out_last, 1'b1);
        wait_idle();

        // Sweep every mode/op with distinct byte patterns; the model covers the data.
        for (int m = 0; m < 8; m++) begin
            for (int o = 0; o < 4; o++) begin
                for (int i = 0; i < 32; i++) begin
                    ta[8*i +: 8] = 8'(i * 7 + m);
                    tb[8*i +: 8] = 8'hC0 ^ 8'(i * 3 + o);
                end
                out_ready = 1'b1;
                send_cmd(ta, tb, 3'(m), 2'(o));
                if (o == 3) begin
                    out_ready = 1'b0;
                    repeat (2) @(posedge clk);
                    #1 out_ready = 1'b1;
                end
                wait_idle();
            end
        end

        // Counter wrap and 1-beat throughput from a fresh reset.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        prev_acc  = 0;
        for (int n = 0; n < 17; n++) begin
            send_cmd({8{32'h0BAD_0000 + 32'(n)}}, {8{32'h1234_5678}}, 3'd2, 2'd0);
            if (n > 0) chk("accept_interval", 256'(acc_cyc - prev_acc), 256'd2);
            prev_acc = acc_cyc;
        end
        @(posedge clk); #1;
        chk("wrap_done_cnt", done_cnt, 4'd1);

        // Reset during BEAT0 drops the command.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b0;
        send_cmd(pa, pb, 3'd4, 2'd2);
        chk("mid_b0_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_done", done_cnt, 4'd0);
        out_ready = 1'b1;
        send_cmd(pa, pb, 3'd3, 2'd0);
        chk("post_rst_data", out_data, {64'h1, 64'h11, 64'h0, 64'h10});
        @(posedge clk); #1;
        chk("post_rst_done", done_cnt, 4'd1);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
